hazard_scoreboard: RTL and testbench

Parametrised hazard scoreboard for the 5-stage MIPS pipeline. It decodes the instruction in ID into source registers, use stage, destination and ready stage, and tracks every in-flight producer in an NSTAGE-deep shift register. From this it raises `stall` and drives forwarding-source selects for both the ID and EX consumers. It generalises the ID-stage class decode to a configurable pipeline depth, configurable result latencies and a no-forwarding mode.

---
 rtl/hazard_scoreboard.sv | 177 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage MIPS pipeline. It decodes the ID instruction
// and tracks in-flight producers per stage. From these it derives stall and the ID/EX forwarding selects.
module hazard_scoreboard #(
  parameter int unsigned  NSTAGE     = 3,
  parameter int unsigned  CAL_STAGE  = 2,
  parameter int unsigned  LOAD_STAGE = 3,
  parameter int unsigned  JAL_STAGE  = 1,
  parameter bit           FWD_EN     = 1'b1,
  localparam int unsigned SW         = $clog2(NSTAGE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   id_instr,
  input  logic          id_valid,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] id_rs_src,
  output logic [SW-1:0] id_rt_src,
  output logic [SW-1:0] ex_rs_src,
  output logic [SW-1:0] ex_rt_src
);
  typedef enum logic [1:0] {P_NONE, P_CAL, P_LOAD, P_JAL} prod_e;

  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd, dest;
  logic          rs_used, rt_used;
  logic [1:0]    rs_use, rt_use;
  prod_e         prod;
  logic [SW-1:0] rdy;
  logic          unused_shamt;

  logic [NSTAGE:1] valid_q, valid_d;
  logic [4:0]      dest_q [NSTAGE:1];
  logic [4:0]      dest_d [NSTAGE:1];
  logic [SW-1:0]   rdy_q  [NSTAGE:1];
  logic [SW-1:0]   rdy_d  [NSTAGE:1];
  logic [4:0]      e1_rs_q, e1_rs_d, e1_rt_q, e1_rt_d;
  logic            e1_rs_used_q, e1_rs_used_d, e1_rt_used_q, e1_rt_used_d;

  assign opcode       = id_instr[31:26];
  assign rs           = id_instr[25:21];
  assign rt           = id_instr[20:16];
  assign rd           = id_instr[15:11];
  assign funct        = id_instr[5:0];
  assign unused_shamt = ^id_instr[10:6];

  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    rs_use  = 2'd0;
    rt_use  = 2'd0;
    dest    = 5'd0;
    prod    = P_NONE;
    unique case (opcode)
      6'h00: begin
        unique case (funct)
          6'h21, 6'h23, 6'h2a, 6'h26: begin
            rs_used = 1'b1; rs_use = 2'd1;
            rt_used = 1'b1; rt_use = 2'd1;
            dest = rd; prod = P_CAL;
          end
          6'h00: begin
            rt_used = 1'b1; rt_use = 2'd1;
            dest = rd; prod = P_CAL;
          end
          6'h08: rs_used = 1'b1;
          default: ;
        endcase
      end
      6'h08, 6'h09, 6'h0c, 6'h0d: begin
        rs_used = 1'b1; rs_use = 2'd1;
        dest = rt; prod = P_CAL;
      end
      6'h0f: begin
        dest = rt; prod = P_CAL;
      end
      6'h23: begin
        rs_used = 1'b1; rs_use = 2'd1;
        dest = rt; prod = P_LOAD;
      end
      6'h2b: begin
        rs_used = 1'b1; rs_use = 2'd1;
        rt_used = 1'b1; rt_use = 2'd2;
      end
      6'h04: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      6'h03: begin
        dest = 5'd31; prod = P_JAL;
      end
      default: ;
    endcase
    if (!FWD_EN) begin
      rs_use = 2'd0;
      rt_use = 2'd0;
    end
  end

  always_comb begin
    rdy = '0;
    unique case (prod)
      P_CAL:   rdy = SW'(CAL_STAGE);
      P_LOAD:  rdy = SW'(LOAD_STAGE);
      P_JAL:   rdy = SW'(JAL_STAGE);
      default: rdy = '0;
    endcase
    if (!FWD_EN) rdy = SW'(NSTAGE);
  end

  // First match scanning upward gives the youngest producer of each register.
  always_comb begin
    stall     = 1'b0;
    id_rs_src = '0;
    id_rt_src = '0;
    ex_rs_src = '0;
    ex_rt_src = '0;
    for (int unsigned k = 1; k <= NSTAGE; k++) begin
      if (valid_q[k] && rs != 5'd0 && dest_q[k] == rs) begin
        if (rs_used && (k + 32'(rs_use)) < 32'(rdy_q[k])) stall = 1'b1;
        if (id_rs_src == '0) id_rs_src = SW'(k);
      end
      if (valid_q[k] && rt != 5'd0 && dest_q[k] == rt) begin
        if (rt_used && (k + 32'(rt_use)) < 32'(rdy_q[k])) stall = 1'b1;
        if (id_rt_src == '0) id_rt_src = SW'(k);
      end
    end
    for (int unsigned k = 2; k <= NSTAGE; k++) begin
      if (valid_q[k] && e1_rs_q != 5'd0 && dest_q[k] == e1_rs_q && ex_rs_src == '0)
        ex_rs_src = SW'(k);
      if (valid_q[k] && e1_rt_q != 5'd0 && dest_q[k] == e1_rt_q && ex_rt_src == '0)
        ex_rt_src = SW'(k);
    end
    stall = stall & id_valid;
    if (!FWD_EN || !rs_used) id_rs_src = '0;
    if (!FWD_EN || !rt_used) id_rt_src = '0;
    if (!FWD_EN || !valid_q[1] || !e1_rs_used_q) ex_rs_src = '0;
    if (!FWD_EN || !valid_q[1] || !e1_rt_used_q) ex_rt_src = '0;
  end

  always_comb begin
    valid_d[1]   = id_valid & ~stall & ~flush;
    dest_d[1]    = dest;
    rdy_d[1]     = rdy;
    e1_rs_d      = rs;
    e1_rt_d      = rt;
    e1_rs_used_d = rs_used;
    e1_rt_used_d = rt_used;
    for (int unsigned k = 2; k <= NSTAGE; k++) begin
      valid_d[k] = valid_q[k-1];
      dest_d[k]  = dest_q[k-1];
      rdy_d[k]   = rdy_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      e1_rs_q      <= '0;
      e1_rt_q      <= '0;
      e1_rs_used_q <= 1'b0;
      e1_rt_used_q <= 1'b0;
      for (int unsigned k = 1; k <= NSTAGE; k++) begin
        dest_q[k] <= '0;
        rdy_q[k]  <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      dest_q       <= dest_d;
      rdy_q        <= rdy_d;
      e1_rs_q      <= e1_rs_d;
      e1_rt_q      <= e1_rt_d;
      e1_rs_used_q <= e1_rs_used_d;
      e1_rt_used_q <= e1_rt_used_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard. It runs a forwarding instance and a
// register-file-only instance in lockstep, each checked against its own behavioural model.
module tb_hazard_scoreboard;
  localparam int NS = 3, CAL = 2, LOAD = 3, JAL = 1;

  logic        clk, reset, id_valid, flush;
  logic [31:0] id_instr;
  logic        stall0, stall1;
  logic [1:0]  idrs0, idrt0, exrs0, exrt0, idrs1, idrt1, exrs1, exrt1;

  hazard_scoreboard #(.NSTAGE(NS), .CAL_STAGE(CAL), .LOAD_STAGE(LOAD), .JAL_STAGE(JAL), .FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
    .stall(stall0), .id_rs_src(idrs0), .id_rt_src(idrt0), .ex_rs_src(exrs0), .ex_rt_src(exrt0));

  hazard_scoreboard #(.NSTAGE(NS), .CAL_STAGE(CAL), .LOAD_STAGE(LOAD), .JAL_STAGE(JAL), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
    .stall(stall1), .id_rs_src(idrs1), .id_rt_src(idrt1), .ex_rs_src(exrs1), .ex_rt_src(exrt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {C_NOP, C_CALR, C_SLL, C_CALI, C_LUI, C_LW, C_SW, C_BEQ, C_JR, C_JAL} cls_e;
  typedef struct {bit v; int dest; int rdy; int rs; int rt; bit rsu; bit rtu;} ent_t;

  ent_t pipe [2][1:NS];
  int   exp_o [2][5];
  int   obs   [2][5];
  bit   last_st [2];

  function automatic cls_e classify(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00: case (fn)
               6'h21, 6'h23, 6'h2a, 6'h26: return C_CALR;
               6'h00: return C_SLL;
               6'h08: return C_JR;
               default: return C_NOP;
             endcase
      6'h08, 6'h09, 6'h0c, 6'h0d: return C_CALI;
      6'h0f: return C_LUI;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      6'h04: return C_BEQ;
      6'h03: return C_JAL;
      default: return C_NOP;
    endcase
  endfunction

  function automatic void decode(input logic [31:0] ins, input bit fwd,
                                 output int rs, output int rt, output bit rsu, output bit rtu,
                                 output int us, output int ut, output int dst, output int rdy);
    cls_e c;
    c = classify(ins);
    rs = int'(ins[25:21]); rt = int'(ins[20:16]);
    rsu = 0; rtu = 0; us = 0; ut = 0; dst = 0; rdy = 0;
    case (c)
      C_CALR: begin rsu = 1; us = 1; rtu = 1; ut = 1; dst = int'(ins[15:11]); rdy = CAL; end
      C_SLL:  begin rtu = 1; ut = 1; dst = int'(ins[15:11]); rdy = CAL; end
      C_CALI: begin rsu = 1; us = 1; dst = rt; rdy = CAL; end
      C_LUI:  begin dst = rt; rdy = CAL; end
      C_LW:   begin rsu = 1; us = 1; dst = rt; rdy = LOAD; end
      C_SW:   begin rsu = 1; us = 1; rtu = 1; ut = 2; end
      C_BEQ:  begin rsu = 1; rtu = 1; end
      C_JR:   rsu = 1;
      C_JAL:  begin dst = 31; rdy = JAL; end
      default: ;
    endcase
    if (!fwd) begin
      us = 0; ut = 0;
      if (rdy != 0) rdy = NS;
    end
  endfunction

  function automatic bit producer_at(input int m, input int k, input int r);
    return pipe[m][k].v && r != 0 && pipe[m][k].dest == r;
  endfunction

  function automatic void model_eval(input int m, input logic [31:0] ins, input bit v);
    int rs, rt, us, ut, dst, rdy;
    bit rsu, rtu, fwd, st;
    int src [2];
    int ex  [2];
    fwd = (m == 0);
    decode(ins, fwd, rs, rt, rsu, rtu, us, ut, dst, rdy);
    st = 0;
    src = '{0, 0};
    ex  = '{0, 0};
    for (int k = NS; k >= 1; k--) begin
      if (rsu && producer_at(m, k, rs)) begin
        if (k + us < pipe[m][k].rdy) st = 1;
        if (fwd) src[0] = k;
      end
      if (rtu && producer_at(m, k, rt)) begin
        if (k + ut < pipe[m][k].rdy) st = 1;
        if (fwd) src[1] = k;
      end
    end
    if (fwd && pipe[m][1].v) begin
      for (int k = NS; k >= 2; k--) begin
        if (pipe[m][1].rsu && producer_at(m, k, pipe[m][1].rs)) ex[0] = k;
        if (pipe[m][1].rtu && producer_at(m, k, pipe[m][1].rt)) ex[1] = k;
      end
    end
    exp_o[m] = '{int'(st && v), src[0], src[1], ex[0], ex[1]};
  endfunction

  function automatic void model_update(input int m, input logic [31:0] ins, input bit v,
                                       input bit fl, input bit rst, input bit st);
    int rs, rt, us, ut, dst, rdy;
    bit rsu, rtu;
    if (rst) begin
      for (int k = 1; k <= NS; k++) pipe[m][k].v = 0;
      return;
    end
    decode(ins, m == 0, rs, rt, rsu, rtu, us, ut, dst, rdy);
    for (int k = NS; k >= 2; k--) pipe[m][k] = pipe[m][k-1];
    pipe[m][1] = '{v && !st && !fl, dst, rdy, rs, rt, rsu, rtu};
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] r_ins(input int fn, input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic int rreg();
    int pool [5];
    pool = '{0, 1, 2, 3, 31};
    return pool[$urandom_range(0, 4)];
  endfunction

  function automatic logic [31:0] rand_instr();
    if ($urandom_range(0, 9) == 0) return $urandom();
    case ($urandom_range(0, 15))
      0:  return r_ins('h21, rreg(), rreg(), rreg());
      1:  return r_ins('h23, rreg(), rreg(), rreg());
      2:  return r_ins('h2a, rreg(), rreg(), rreg());
      3:  return r_ins('h00, 0, rreg(), rreg());
      4:  return r_ins('h26, rreg(), rreg(), rreg());
      5:  return i_ins('h0d, rreg(), rreg(), 5);
      6:  return i_ins('h08, rreg(), rreg(), 1);
      7:  return i_ins('h09, rreg(), rreg(), 2);
      8:  return i_ins('h0c, rreg(), rreg(), 3);
      9:  return i_ins('h0f, rreg(), rreg(), 7);
      10: return i_ins('h23, rreg(), rreg(), 0);
      11: return i_ins('h2b, rreg(), rreg(), 4);
      12: return i_ins('h04, rreg(), rreg(), 1);
      13: return r_ins('h08, rreg(), 0, 0);
      14: return {6'h03, 26'h40};
      default: return {6'h02, 26'h40};
    endcase
  endfunction

  task automatic step(input logic [31:0] ins, input bit v, input bit fl, input bit rst);
    string names [5];
    names = '{"stall", "id_rs_src", "id_rt_src", "ex_rs_src", "ex_rt_src"};
    id_instr = ins; id_valid = v; flush = fl; reset = rst;
    @(negedge clk);
    obs[0] = '{int'(stall0), int'(idrs0), int'(idrt0), int'(exrs0), int'(exrt0)};
    obs[1] = '{int'(stall1), int'(idrs1), int'(idrt1), int'(exrs1), int'(exrt1)};
    for (int m = 0; m < 2; m++) begin
      model_eval(m, ins, v);
      last_st[m] = exp_o[m][0] != 0;
      for (int i = 0; i < 5; i++)
        check({(m == 1) ? "nf_" : "", names[i]}, obs[m][i], exp_o[m][i]);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_update(m, ins, v, fl, rst, last_st[m]);
    #1;
  endtask

  task automatic issue(input int m, input logic [31:0] ins, output int nstall);
    nstall = 0;
    for (int c = 0; c < 10; c++) begin
      step(ins, 1, 0, 0);
      if (!last_st[m]) return;
      nstall++;
    end
    check("issue_timeout", 1, 0);
  endtask

  task automatic drain();
    repeat (4) step(32'h0, 0, 0, 0);
  endtask

  int ns;
  logic [31:0] cur;
  bit rr, vv, ff;

  initial begin
    reset = 1'b1; id_valid = 1'b1; flush = 1'b0;
    id_instr = r_ins('h21, 8, 8, 9);
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++)
      for (int k = 1; k <= NS; k++) pipe[m][k].v = 0;

    // reset state with a would-be consumer held in ID
    step(r_ins('h21, 8, 8, 9), 1, 0, 1);
    check("rst_stall", obs[0][0], 0);
    check("rst_id_rs", obs[0][1], 0);
    check("rst_ex_rs", obs[0][3], 0);
    drain();

    // load-use
    issue(0, i_ins('h23, 1, 8, 0), ns);
    issue(0, r_ins('h21, 8, 8, 9), ns);
    check("lw_use_stalls", ns, 1);
    check("lw_use_id_rs", obs[0][1], 2);
    check("lw_use_id_rt", obs[0][2], 2);
    step(32'h0, 0, 0, 0);
    drain();

    // branch after ALU, jr after jal
    issue(0, r_ins('h21, 1, 2, 3), ns);
    issue(0, i_ins('h04, 3, 0, 4), ns);
    check("beq_stalls", ns, 1);
    check("beq_id_rs", obs[0][1], 2);
    drain();
    issue(0, {6'h03, 26'h40}, ns);
    issue(0, r_ins('h08, 31, 0, 0), ns);
    check("jr_stalls", ns, 0);
    check("jr_id_rs", obs[0][1], 1);
    drain();

    // load feeding store data, and $0 destination
    issue(0, i_ins('h23, 1, 5, 0), ns);
    issue(0, i_ins('h2b, 6, 5, 4), ns);
    check("sw_stalls", ns, 0);
    step(32'h0, 0, 0, 0);
    check("sw_ex_rt", obs[0][4], 2);
    drain();
    issue(0, i_ins('h0d, 1, 0, 5), ns);
    issue(0, r_ins('h21, 0, 0, 2), ns);
    check("r0_stalls", ns, 0);
    check("r0_id_rs", obs[0][1], 0);
    drain();

    // no-forwarding instance
    issue(1, r_ins('h21, 1, 2, 4), ns);
    issue(1, r_ins('h23, 4, 4, 5), ns);
    check("nf_stalls", ns, 2);
    check("nf_id_rs", obs[1][1], 0);
    step(32'h0, 0, 0, 0);
    drain();

    // flush of a load
    step(i_ins('h23, 1, 8, 0), 1, 1, 0);
    issue(0, r_ins('h21, 8, 8, 9), ns);
    check("flush_stalls", ns, 0);
    step(32'h0, 0, 0, 0);
    check("flush_ex_rs", obs[0][3], 0);
    drain();

    // randomized traffic, including mid-stall resets
    cur = rand_instr();
    for (int c = 0; c < 600; c++) begin
      rr = ($urandom_range(0, 59) == 0);
      vv = ($urandom_range(0, 7) != 0);
      ff = ($urandom_range(0, 7) == 0);
      if (!(last_st[0] && $urandom_range(0, 3) != 0)) cur = rand_instr();
      step(cur, vv, ff, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
